// File: rtl/prod_accum_pkg.sv
// Shared types and helpers for the prod_accum frame accumulator.
// sat_clamp is used only when PROD_ACCUM_SAT_EN is defined.
package prod_accum_pkg;

  localparam int PROD_W = 16;

  typedef logic signed [PROD_W-1:0] prod_t;

  // Clamp a sign-extended sum into the signed range of a width-bit result.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] sum,
                                                   input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sum > hi) begin
      sat_clamp = hi;
    end else if (sum < lo) begin
      sat_clamp = lo;
    end else begin
      sat_clamp = sum;
    end
  endfunction

endpackage

// File: rtl/prod_accum_add.sv
// Combinational accumulate adder: acc + sext(term), wrapping by default.
// With PROD_ACCUM_SAT_EN the sum is clamped to ACC_W bits and ovf flags the clamp.
module prod_accum_add
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] acc,
  input  prod_t                   term,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

`ifdef PROD_ACCUM_SAT_EN
  logic signed [ACC_W:0] wide_s;
  logic signed [63:0]    wide64_s;
  logic signed [63:0]    clamped_s;

  // One guard bit is enough to detect overflow of a single add
  assign wide_s    = (ACC_W+1)'(acc) + (ACC_W+1)'(term);
  assign wide64_s  = 64'(wide_s);
  assign clamped_s = sat_clamp(wide64_s, ACC_W);
  assign sum       = ACC_W'(clamped_s);
  assign ovf       = (clamped_s != wide64_s);
`else
  assign sum = acc + ACC_W'(term);
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums frames of N_TERMS signed products into a valid/ready result register.
// Define PROD_ACCUM_SAT_EN for saturating arithmetic with a per-frame out_ovf flag.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  prod_t                   in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data,
  input  logic                    out_ready,
  output logic                    out_ovf
);

  localparam int              CNT_W    = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]        cnt_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    sticky_r;
  logic                    last_s;
  logic                    accept_s;
  logic                    load_s;
  logic signed [ACC_W-1:0] sum_s;
  logic                    add_ovf_s;

  // Only the final term can stall, and only behind an unconsumed result
  assign last_s   = (cnt_r == LAST_CNT);
  assign in_ready = !(last_s && out_valid && !out_ready);
  assign accept_s = in_valid && in_ready;
  assign load_s   = accept_s && last_s && !clr;

  prod_accum_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc  (acc_r),
    .term (in_data),
    .sum  (sum_s),
    .ovf  (add_ovf_s)
  );

  // Partial sum, term counter and per-frame clamp flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      cnt_r    <= '0;
      sticky_r <= 1'b0;
    end else if (clr || (accept_s && last_s)) begin
      acc_r    <= '0;
      cnt_r    <= '0;
      sticky_r <= 1'b0;
    end else if (accept_s) begin
      acc_r    <= sum_s;
      cnt_r    <= cnt_r + CNT_ONE;
      sticky_r <= sticky_r | add_ovf_s;
    end else begin
      acc_r    <= acc_r;
      cnt_r    <= cnt_r;
      sticky_r <= sticky_r;
    end
  end

  // Result register: a load wins over a consume in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      out_data  <= sum_s;
      out_ovf   <= sticky_r | add_ovf_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: two instances (ACC_W 20 and 16, N_TERMS 4)
// share one stimulus stream and are checked every cycle against a frame-level model.
module tb_prod_accum;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_ready;

  logic               in_ready20, out_valid20, out_ovf20;
  logic signed [19:0] out_data20;
  logic               in_ready16, out_valid16, out_ovf16;
  logic signed [15:0] out_data16;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prod_accum #(.N_TERMS(N), .ACC_W(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready20), .out_valid(out_valid20), .out_data(out_data20),
    .out_ready(out_ready), .out_ovf(out_ovf20)
  );

  prod_accum #(.N_TERMS(N), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready16), .out_valid(out_valid16), .out_data(out_data16),
    .out_ready(out_ready), .out_ovf(out_ovf16)
  );

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     cnt_m;
  int     terms_m [N];
  bit     exp_valid;
  longint exp_d20, exp_d16;
  bit     exp_o20, exp_o16;

  function automatic bit model_ready();
    return !(cnt_m == N - 1 && exp_valid && !out_ready);
  endfunction

  // Sum a whole frame at width w: clamp after every add, or wrap once at the end
  function automatic void frame_result(input int last, input int w,
                                       output longint res, output bit ovf);
    longint s, hi, lo;
    s   = 0;
    ovf = 1'b0;
    hi  = (64'sd1 <<< (w - 1)) - 1;
    lo  = -hi - 1;
    for (int i = 0; i < N; i++) begin
      s += (i == N - 1) ? longint'(last) : longint'(terms_m[i]);
`ifdef PROD_ACCUM_SAT_EN
      if (s > hi) begin s = hi; ovf = 1'b1; end
      else if (s < lo) begin s = lo; ovf = 1'b1; end
`endif
    end
`ifndef PROD_ACCUM_SAT_EN
    s = s & ((64'sd1 <<< w) - 1);
    if (s > hi) s -= (64'sd1 <<< w);
`endif
    res = s;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    longint r20, r16;
    bit     o20, o16;
    if (!rst_n) begin
      cnt_m     <= 0;
      exp_valid <= 1'b0;
      exp_d20   <= 0;
      exp_d16   <= 0;
      exp_o20   <= 1'b0;
      exp_o16   <= 1'b0;
    end else begin
      if (in_valid && model_ready() && !clr && cnt_m == N - 1) begin
        frame_result(int'(in_data), 20, r20, o20);
        frame_result(int'(in_data), 16, r16, o16);
        exp_valid <= 1'b1;
        exp_d20   <= r20;
        exp_d16   <= r16;
        exp_o20   <= o20;
        exp_o16   <= o16;
      end else if (out_ready) begin
        exp_valid <= 1'b0;
      end
      if (clr) begin
        cnt_m <= 0;
      end else if (in_valid && model_ready()) begin
        if (cnt_m == N - 1) begin
          cnt_m <= 0;
        end else begin
          terms_m[cnt_m] <= int'(in_data);
          cnt_m          <= cnt_m + 1;
        end
      end
    end
  end

  // Compare process: inputs change just after posedge, so negedge is stable
  always @(negedge clk) begin
    check("in_ready20", longint'(in_ready20), longint'(model_ready()));
    check("in_ready16", longint'(in_ready16), longint'(model_ready()));
    check("out_valid20", longint'(out_valid20), longint'(exp_valid));
    check("out_valid16", longint'(out_valid16), longint'(exp_valid));
    if (exp_valid) begin
      check("out_data20", longint'(out_data20), exp_d20);
      check("out_data16", longint'(out_data16), exp_d16);
      check("out_ovf20", longint'(out_ovf20), longint'(exp_o20));
      check("out_ovf16", longint'(out_ovf16), longint'(exp_o16));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int d, input bit ordy, input bit c = 1'b0);
    in_valid  = v;
    in_data   = 16'(d);
    out_ready = ordy;
    clr       = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit v, input int d, input bit ordy);
    drive(v, d, ordy);
    tick();
  endtask

  initial begin
    int low_cnt;
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b1);
    tick();
    check("rst_valid", longint'(out_valid20), 0);
    check("rst_data", longint'(out_data20), 0);
    check("rst_ovf", longint'(out_ovf20), 0);
    check("rst_ready", longint'(in_ready20), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Mixed-sign frame
    send(1'b1, 100, 1'b1);
    send(1'b1, -50, 1'b1);
    send(1'b1, 16129, 1'b1);
    send(1'b1, -16384, 1'b1);
    check("t1_valid", longint'(out_valid20), 1);
    check("t1_data", longint'(out_data20), -205);
    send(1'b0, 0, 1'b1);
    check("t1_drop", longint'(out_valid20), 0);

    // Three back-to-back frames of ones
    low_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        drive(1'b1, 1, 1'b1);
        if (in_ready20 !== 1'b1) low_cnt++;
        tick();
      end
      check("t2_valid", longint'(out_valid20), 1);
      check("t2_data", longint'(out_data20), 4);
    end
    check("t2_no_stall", longint'(low_cnt), 0);
    send(1'b0, 0, 1'b1);

    // Backpressure: second final term stalls, then loads on consume
    for (int i = 1; i <= 4; i++) send(1'b1, i, 1'b0);
    for (int i = 5; i <= 7; i++) send(1'b1, i, 1'b0);
    check("t3_held", longint'(out_data20), 10);
    drive(1'b1, 8, 1'b0);
    check("t3_stall", longint'(in_ready20), 0);
    tick();
    check("t3_still", longint'(out_valid20), 1);
    drive(1'b1, 8, 1'b1);
    check("t3_unstall", longint'(in_ready20), 1);
    tick();
    check("t3_valid", longint'(out_valid20), 1);
    check("t3_data", longint'(out_data20), 26);
    send(1'b0, 0, 1'b1);

    // Overflow of the 16-bit instance
    for (int i = 0; i < N; i++) send(1'b1, 16129, 1'b1);
    check("t4_data20", longint'(out_data20), 64516);
`ifdef PROD_ACCUM_SAT_EN
    check("t4_data16", longint'(out_data16), 32767);
    check("t4_ovf16", longint'(out_ovf16), 1);
`else
    check("t4_data16", longint'(out_data16), -1020);
    check("t4_ovf16", longint'(out_ovf16), 0);
`endif
    send(1'b0, 0, 1'b1);

    // Frame abort with a same-cycle input discarded
    send(1'b1, 1000, 1'b1);
    send(1'b1, 2000, 1'b1);
    drive(1'b1, 9999, 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= 4; i++) send(1'b1, i, 1'b1);
    check("t5_valid", longint'(out_valid20), 1);
    check("t5_data", longint'(out_data20), 10);
    send(1'b0, 0, 1'b1);

    // Reset mid-frame with a pending result
    for (int i = 0; i < N; i++) send(1'b1, 7, 1'b0);
    send(1'b1, 1, 1'b0);
    send(1'b1, 1, 1'b0);
    check("t6_pending", longint'(out_valid20), 1);
    rst_n = 1'b0;
    #1;
    check("t6_valid", longint'(out_valid20), 0);
    check("t6_data", longint'(out_data20), 0);
    check("t6_ovf", longint'(out_ovf20), 0);
    check("t6_ready", longint'(in_ready20), 1);
    drive(1'b0, 0, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) send(1'b1, 5, 1'b1);
    check("t6_valid2", longint'(out_valid20), 1);
    check("t6_data2", longint'(out_data20), 20);
    send(1'b0, 0, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
